// File: rtl/apb_slave_pkg.sv
// rtl/apb_slave_pkg.sv - shared types and constants for the APB register slave
package apb_slave_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_IDX_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [APB_IDX_W-1:0] idx;
        logic                 err;
        logic                 wr;
    } dec_t;

endpackage

// File: rtl/apb_reg_decode.sv
// rtl/apb_reg_decode.sv - combinational address/access decode for apb_reg_slave
// Optional APB_REG_PROT_CHECK_EN adds the privileged-region check (PRIV_BASE).
module apb_reg_decode
    import apb_slave_pkg::*;
#(
    parameter int                  ADDR_W   = 32,
    parameter int                  NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK  = 8'b1100_0000
`ifdef APB_REG_PROT_CHECK_EN
    , parameter int                PRIV_BASE = NUM_REGS / 2
`endif
) (
    input  logic [ADDR_W-1:0]    paddr,
    input  logic                 pwrite,
    input  logic [2:0]           pprot,
    output logic [APB_IDX_W-1:0] idx,
    output logic                 addr_err,
    output logic                 ro_err,
    output logic                 prot_err
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [IDX_W-1:0] w_idx;
    logic             w_unused_prot;

    assign w_idx    = paddr[IDX_W+1:2];
    assign idx      = APB_IDX_W'(w_idx);
    // Any set bit above the register window or in the byte offset is an error.
    assign addr_err = (paddr[ADDR_W-1:IDX_W+2] != '0) || (paddr[1:0] != 2'b00);
    assign ro_err   = pwrite & RO_MASK[w_idx];

`ifdef APB_REG_PROT_CHECK_EN
    assign prot_err      = ~pprot[0] & (32'(w_idx) >= 32'(PRIV_BASE));
    assign w_unused_prot = ^pprot[2:1];
`else
    assign prot_err      = 1'b0;
    assign w_unused_prot = ^pprot;
`endif

endmodule

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB4 completer register bank with RW control and RO status registers
// Optional APB_REG_PROT_CHECK_EN rejects unprivileged accesses to idx >= PRIV_BASE.
module apb_reg_slave
    import apb_slave_pkg::*;
#(
    parameter int                  ADDR_W      = 32,
    parameter int                  DATA_W      = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK     = 8'b1100_0000,
    parameter logic [31:0]         RST_VAL     = 32'h0
`ifdef APB_REG_PROT_CHECK_EN
    , parameter int                PRIV_BASE   = NUM_REGS / 2
`endif
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   pselx,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [ADDR_W-1:0]      paddr,
    input  logic [DATA_W-1:0]      pwdata,
    input  logic [3:0]             pstrb,
    input  logic [2:0]             pprot,
    output logic [DATA_W-1:0]      prdata,
    output logic                   pready,
    output logic                   pslverr,
    output logic [NUM_REGS*32-1:0] rw_out,
    input  logic [NUM_REGS*32-1:0] ro_in
);

    localparam int IDX_W = $clog2(NUM_REGS);

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic            w_capture;
    dec_t            r_dec, w_dec;
    logic [31:0]     r_wdata;
    logic [3:0]      r_strb;
    logic [31:0]     r_regs [NUM_REGS];
    logic [31:0]     w_ro   [NUM_REGS];
    logic [APB_IDX_W-1:0] w_idx;
    logic            w_addr_err, w_ro_err, w_prot_err;
    logic [IDX_W-1:0] w_ridx;
    logic [31:0]     w_rdata;
    logic            w_unused_idx;

    apb_reg_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK)
`ifdef APB_REG_PROT_CHECK_EN
        , .PRIV_BASE(PRIV_BASE)
`endif
    ) u_decode (
        .paddr    (paddr),
        .pwrite   (pwrite),
        .pprot    (pprot),
        .idx      (w_idx),
        .addr_err (w_addr_err),
        .ro_err   (w_ro_err),
        .prot_err (w_prot_err)
    );

    assign w_dec.idx = w_idx;
    assign w_dec.err = w_addr_err | w_ro_err | w_prot_err;
    assign w_dec.wr  = pwrite;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (pselx && !penable) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = 4'(WAIT_STATES);
                    w_state_nxt = (WAIT_STATES > 0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (!pselx) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (penable) begin
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The decode result and write payload are frozen at setup time.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_dec   <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if (w_capture) begin
            r_dec   <= w_dec;
            r_wdata <= pwdata;
            r_strb  <= pstrb;
        end
    end

    assign w_ridx       = r_dec.idx[IDX_W-1:0];
    assign w_unused_idx = ^r_dec.idx;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RST_VAL;
            end
        end else if (r_state == DONE && r_dec.wr && !r_dec.err) begin
            for (int b = 0; b < 4; b++) begin
                if (r_strb[b]) begin
                    r_regs[w_ridx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slices
        assign w_ro[i]            = ro_in[32*i +: 32];
        assign rw_out[32*i +: 32] = r_regs[i];
    end

    assign w_rdata = RO_MASK[w_ridx] ? w_ro[w_ridx] : r_regs[w_ridx];
    assign pready  = (r_state == DONE);
    assign pslverr = pready & r_dec.err;
    assign prdata  = (pready && !r_dec.err && !r_dec.wr) ? w_rdata : '0;

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - scoreboard bench for apb_reg_slave with a behavioural register model
module tb_apb_reg_slave;

    localparam int          NR  = 8;
    localparam int          WS  = 1;
    localparam logic [7:0]  ROM = 8'b1100_0000;
    localparam logic [31:0] RV  = 32'h0;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          pselx, penable, pwrite;
    logic [31:0]   paddr, pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic [31:0]   prdata;
    logic          pready, pslverr;
    logic [NR*32-1:0] rw_out;
    logic [NR*32-1:0] ro_in;

    apb_reg_slave #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGS(NR), .WAIT_STATES(WS),
        .RO_MASK(ROM), .RST_VAL(RV)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .pselx(pselx), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .rw_out(rw_out), .ro_in(ro_in)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model  [NR];
    logic [31:0] ro_val [NR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ro(input int i, input logic [31:0] v);
        ro_val[i]          = v;
        ro_in[32*i +: 32]  = v;
    endtask

    // Reference behaviour: address window, alignment, RO and privilege rules, byte strobes.
    function automatic exp_t predict(input logic [31:0] addr, input bit wr, input logic [31:0] data,
                                     input logic [3:0] strb, input logic [2:0] prot);
        exp_t e;
        bit   err;
        int   idx;
        err = (addr >= NR * 4) || (addr % 4 != 0);
        idx = int'(addr / 4);
        if (!err && wr && ROM[idx]) err = 1;
`ifdef APB_REG_PROT_CHECK_EN
        if (!err && !prot[0] && idx >= NR / 2) err = 1;
`else
        if (prot == 3'd7) err = err;
`endif
        e.rd   = !wr;
        e.err  = err;
        e.data = 32'h0;
        if (!err && !wr) e.data = ROM[idx] ? ro_val[idx] : model[idx];
        if (!err && wr) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
        return e;
    endfunction

    task automatic check_regs();
        for (int i = 0; i < NR; i++) begin
            if (!ROM[i]) check($sformatf("rw_out[%0d]", i), rw_out[32*i +: 32], model[i]);
        end
    endtask

    // Called at #1 after a posedge; returns at #1 after a posedge.
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot);
        int n;
        bit done;
        q.push_back(predict(addr, wr, data, strb, prot));
        pselx = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot;
        @(posedge aclk); #1;
        penable = 1;
        n = 0; done = 0;
        while (!done && n < 40) begin
            @(negedge aclk);
            n++;
            if (pready) done = 1;
        end
        check("latency", n, 1 + WS);
        @(posedge aclk); #1;
        pselx = 0; penable = 0; paddr = $urandom; pwdata = $urandom;
        check_regs();
    endtask

    always @(negedge aclk) begin
        if (pready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pready actual=1 expected=0 at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pslverr", 32'(pslverr), 32'(e.err));
                if (e.rd || e.err) check("prdata", prdata, e.data);
            end
        end else begin
            check("idle_pslverr", 32'(pslverr), 32'h0);
            check("idle_prdata", prdata, 32'h0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 0; pselx = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0; pprot = 0;
        ro_in = '0;
        for (int i = 0; i < NR; i++) begin
            model[i] = RV;
            set_ro(i, $urandom);
        end
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_pready", 32'(pready), 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check_regs();
        @(posedge aclk); #1;
        aresetn = 1;

        xfer(32'h00, 0, 32'h0, 4'h0, 3'b001);
        xfer(32'h04, 1, 32'hDEADBEEF, 4'b0101, 3'b001);
        xfer(32'h04, 0, 32'h0, 4'h0, 3'b001);
        check("reg1_strobed", rw_out[63:32], 32'h00AD00EF);

        set_ro(6, 32'h1234);
        xfer(32'h18, 1, 32'hFFFF_FFFF, 4'hF, 3'b001);
        xfer(32'h18, 0, 32'h0, 4'h0, 3'b001);
        xfer(32'h20, 0, 32'h0, 4'h0, 3'b001);
        xfer(32'h02, 1, 32'h5555_5555, 4'hF, 3'b001);
        xfer(32'h0C, 1, 32'hA5A5_A5A5, 4'h0, 3'b001);
        xfer(32'h08, 1, 32'h1111_2222, 4'hF, 3'b001);

        // Reset during the wait state of a write to reg 2.
        pselx = 1; penable = 0; pwrite = 1; paddr = 32'h08; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        @(posedge aclk); #1;
        penable = 1;
        #2 aresetn = 0;
        #1;
        check("midrst_pready", 32'(pready), 32'h0);
        check("midrst_pslverr", 32'(pslverr), 32'h0);
        check("midrst_prdata", prdata, 32'h0);
        check("midrst_reg2", rw_out[95:64], RV);
        for (int i = 0; i < NR; i++) model[i] = RV;
        pselx = 0; penable = 0;
        @(posedge aclk); #1;
        aresetn = 1;
        xfer(32'h08, 0, 32'h0, 4'h0, 3'b001);
        xfer(32'h08, 1, 32'h0BAD_CAFE, 4'hF, 3'b001);

        // Bridge abort: select drops during the wait state.
        pselx = 1; penable = 0; pwrite = 1; paddr = 32'h0C; pwdata = 32'h7777_7777; pstrb = 4'hF;
        @(posedge aclk); #1;
        pselx = 0;
        repeat (3) begin
            @(negedge aclk);
            check("abort_pready", 32'(pready), 32'h0);
        end
        @(posedge aclk); #1;
        check_regs();

`ifdef APB_REG_PROT_CHECK_EN
        xfer(32'h10, 1, 32'h1357_9BDF, 4'hF, 3'b000);
        xfer(32'h10, 1, 32'h1357_9BDF, 4'hF, 3'b001);
        check("prot_commit", rw_out[159:128], 32'h1357_9BDF);
`endif

        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(8, 15)) * 4;
                1:       a = (32'($urandom_range(0, 7)) * 4) | 32'($urandom_range(1, 3));
                2:       a = $urandom | 32'h100;
                default: a = 32'($urandom_range(0, 7)) * 4;
            endcase
            if ($urandom_range(0, 7) == 0) set_ro($urandom_range(6, 7), $urandom);
            xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge aclk);
            #1;
        end

        repeat (3) @(posedge aclk);
        check("queue_empty", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
